// File: rtl/seg_pkg.sv
// Shared definitions for the multiplexed 7-segment scan controller:
// FSM state encoding, dark-output constants and the hex-to-segment table.
package seg_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StBlank = 2'd1,
        StDrive = 2'd2
    } state_e;

    // Segment bus and anodes are active low, so all-ones is dark.
    localparam logic [6:0] SEG_OFF   = 7'h7F;
    localparam logic       ANODE_OFF = 1'b1;

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
        logic [6:0] seg;
        unique case (nibble)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational hex nibble to active-low 7-segment pattern.
module seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] nibble_i,
    output logic [6:0] seg_o
);

    // Pure table lookup shared with the package so there is one source of truth.
    always_comb begin
        seg_o = hex_to_seg(nibble_i);
    end

endmodule

// File: rtl/seg_scan_controller.sv
// Time-shares one active-low 7-segment bus across NUM_DIGITS positions.
// Each frame works from a snapshot of the inputs taken at frame start; every
// digit gets a dark BLANK slot (anti-ghosting) followed by a DRIVE slot.
module seg_scan_controller
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned DWELL_CYCLES = 50000,
    parameter int unsigned BLANK_CYCLES = 500
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          enable_i,
    input  logic [4*NUM_DIGITS-1:0]       digits_i,
    input  logic [NUM_DIGITS-1:0]         blank_mask_i,
    input  logic                          lz_en_i,
    output logic [6:0]                    seg_out_o,
    output logic [NUM_DIGITS-1:0]         anode_o,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_sel_o,
    output logic                          frame_done_o
);

    localparam int unsigned SelW   = $clog2(NUM_DIGITS);
    localparam int unsigned CntMax = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int unsigned CntW   = $clog2(CntMax + 1);

    localparam logic [SelW-1:0] LastIdx   = SelW'(NUM_DIGITS - 1);
    localparam logic [CntW-1:0] DwellLast = CntW'(DWELL_CYCLES - 1);
    // Only meaningful when BLANK_CYCLES > 0; the BLANK state is unreachable otherwise.
    localparam logic [CntW-1:0] BlankLast = CntW'(BLANK_CYCLES - 1);
    // Slot that starts every digit: BLANK, or straight to DRIVE with no blanking.
    localparam state_e          SlotStart = (BLANK_CYCLES == 0) ? StDrive : StBlank;

    state_e                  state_q, state_d;
    logic [SelW-1:0]         idx_q, idx_d;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic [4*NUM_DIGITS-1:0] snap_dig_q, snap_dig_d;
    logic [NUM_DIGITS-1:0]   snap_mask_q, snap_mask_d;
    logic                    snap_lz_q, snap_lz_d;

    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   anode_q, anode_d;
    logic [SelW-1:0]         sel_q, sel_d;
    logic                    fd_q, fd_d;

    logic [3:0]              cur_nib;
    logic [6:0]              dec_seg;
    logic [NUM_DIGITS:0]     zero_from;
    logic                    dark;

    // State, counter, snapshot and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            cnt_q       <= '0;
            snap_dig_q  <= '0;
            snap_mask_q <= '0;
            snap_lz_q   <= 1'b0;
            seg_q       <= SEG_OFF;
            anode_q     <= {NUM_DIGITS{ANODE_OFF}};
            sel_q       <= '0;
            fd_q        <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            snap_dig_q  <= snap_dig_d;
            snap_mask_q <= snap_mask_d;
            snap_lz_q   <= snap_lz_d;
            seg_q       <= seg_d;
            anode_q     <= anode_d;
            sel_q       <= sel_d;
            fd_q        <= fd_d;
        end
    end

    // Next-state: slot sequencing, digit index and frame-start snapshots.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        cnt_d       = cnt_q;
        snap_dig_d  = snap_dig_q;
        snap_mask_d = snap_mask_q;
        snap_lz_d   = snap_lz_q;
        if (!enable_i) begin
            state_d = StIdle;
            idx_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    state_d     = SlotStart;
                    idx_d       = '0;
                    cnt_d       = '0;
                    snap_dig_d  = digits_i;
                    snap_mask_d = blank_mask_i;
                    snap_lz_d   = lz_en_i;
                end
                StBlank: begin
                    if (cnt_q == BlankLast) begin
                        state_d = StDrive;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StDrive: begin
                    if (cnt_q == DwellLast) begin
                        state_d = SlotStart;
                        cnt_d   = '0;
                        if (idx_q == LastIdx) begin
                            idx_d       = '0;
                            snap_dig_d  = digits_i;
                            snap_mask_d = blank_mask_i;
                            snap_lz_d   = lz_en_i;
                        end else begin
                            idx_d = idx_q + SelW'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign cur_nib = snap_dig_d[{idx_d, 2'b00} +: 4];

    seg7_decode u_decode (
        .nibble_i (cur_nib),
        .seg_o    (dec_seg)
    );

    // Outputs are computed from the next state so the flops present them in
    // the same cycle the state register reaches that state.
    always_comb begin
        zero_from[NUM_DIGITS] = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_from[i] = zero_from[i+1] && (snap_dig_d[4*i +: 4] == 4'h0);
        end
        // Digit 0 is exempt from leading-zero blanking so a zero value still shows.
        dark = snap_mask_d[idx_d] || (snap_lz_d && (idx_d != '0) && zero_from[idx_d]);

        seg_d   = SEG_OFF;
        anode_d = {NUM_DIGITS{ANODE_OFF}};
        sel_d   = idx_d;
        fd_d    = 1'b0;
        if (state_d == StDrive) begin
            if (!dark) begin
                seg_d          = dec_seg;
                anode_d[idx_d] = ~ANODE_OFF;
            end
            fd_d = (idx_d == LastIdx) && (cnt_d == DwellLast);
        end
    end

    assign seg_out_o    = seg_q;
    assign anode_o      = anode_q;
    assign digit_sel_o  = sel_q;
    assign frame_done_o = fd_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Self-checking bench: two controllers (with and without BLANK slots) share
// one set of inputs; a frame-position model predicts every output each cycle.
module tb_seg_scan_controller;

    localparam int NDIG    = 4;
    localparam int DWELL   = 4;
    localparam int BLANK_A = 2;
    localparam int BLANK_B = 0;
    localparam int PER_A   = NDIG * (BLANK_A + DWELL);
    localparam int PER_B   = NDIG * (BLANK_B + DWELL);

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        en  = 1'b1;
    logic        lz  = 1'b0;
    logic [15:0] digits = 16'h12AF;
    logic [3:0]  mask   = 4'h0;

    logic [6:0]  seg_a, seg_b;
    logic [3:0]  anode_a, anode_b;
    logic [1:0]  sel_a, sel_b;
    logic        fd_a, fd_b;

    int checks = 0;
    int errors = 0;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    always #5 clk = ~clk;

    seg_scan_controller #(
        .NUM_DIGITS   (NDIG),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK_A)
    ) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .digits_i     (digits),
        .blank_mask_i (mask),
        .lz_en_i      (lz),
        .seg_out_o    (seg_a),
        .anode_o      (anode_a),
        .digit_sel_o  (sel_a),
        .frame_done_o (fd_a)
    );

    seg_scan_controller #(
        .NUM_DIGITS   (NDIG),
        .DWELL_CYCLES (DWELL),
        .BLANK_CYCLES (BLANK_B)
    ) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .enable_i     (en),
        .digits_i     (digits),
        .blank_mask_i (mask),
        .lz_en_i      (lz),
        .seg_out_o    (seg_b),
        .anode_o      (anode_b),
        .digit_sel_o  (sel_b),
        .frame_done_o (fd_b)
    );

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
        end
    endtask

    // Reference model: position p within the frame plus the frame's snapshot.
    bit          ma_act = 0, mb_act = 0;
    int          ma_p = 0, mb_p = 0;
    logic [15:0] ma_dig = '0, mb_dig = '0;
    logic [3:0]  ma_msk = '0, mb_msk = '0;
    logic        ma_lz = 1'b0, mb_lz = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            ma_act <= 0; ma_p <= 0; ma_dig <= '0; ma_msk <= '0; ma_lz <= 1'b0;
            mb_act <= 0; mb_p <= 0; mb_dig <= '0; mb_msk <= '0; mb_lz <= 1'b0;
        end else if (!en) begin
            ma_act <= 0; ma_p <= 0;
            mb_act <= 0; mb_p <= 0;
        end else begin
            if (!ma_act || ma_p == PER_A - 1) begin
                ma_act <= 1; ma_p <= 0; ma_dig <= digits; ma_msk <= mask; ma_lz <= lz;
            end else begin
                ma_p <= ma_p + 1;
            end
            if (!mb_act || mb_p == PER_B - 1) begin
                mb_act <= 1; mb_p <= 0; mb_dig <= digits; mb_msk <= mask; mb_lz <= lz;
            end else begin
                mb_p <= mb_p + 1;
            end
        end
    end

    task automatic model_exp(input bit act, input int p, input int b, input logic [15:0] dig,
                             input logic [3:0] msk, input logic l, output logic [6:0] seg,
                             output logic [3:0] an, output logic [1:0] sel, output logic fd);
        int d, off;
        logic [15:0] upper;
        logic [3:0] nib;
        seg = 7'h7F; an = 4'hF; sel = 2'd0; fd = 1'b0;
        if (act) begin
            d   = p / (b + DWELL);
            off = p % (b + DWELL);
            sel = 2'(d);
            fd  = (p == NDIG * (b + DWELL) - 1);
            upper = dig >> (4 * d);
            nib   = upper[3:0];
            if (off >= b && !(msk[d] || (l && d != 0 && upper == 16'h0))) begin
                seg = seg_tab[nib];
                an  = ~(4'b0001 << d);
            end
        end
    endtask

    logic [6:0] es;
    logic [3:0] ea;
    logic [1:0] esl;
    logic       efd;

    always @(negedge clk) begin
        model_exp(ma_act, ma_p, BLANK_A, ma_dig, ma_msk, ma_lz, es, ea, esl, efd);
        chk("mon_a_seg", 32'(seg_a), 32'(es));
        chk("mon_a_anode", 32'(anode_a), 32'(ea));
        chk("mon_a_sel", 32'(sel_a), 32'(esl));
        chk("mon_a_fd", 32'(fd_a), 32'(efd));
        model_exp(mb_act, mb_p, BLANK_B, mb_dig, mb_msk, mb_lz, es, ea, esl, efd);
        chk("mon_b_seg", 32'(seg_b), 32'(es));
        chk("mon_b_anode", 32'(anode_b), 32'(ea));
        chk("mon_b_sel", 32'(sel_b), 32'(esl));
        chk("mon_b_fd", 32'(fd_b), 32'(efd));
    end

    task automatic restart(input logic [15:0] d, input logic [3:0] m, input logic l);
        @(negedge clk);
        en = 1'b0;
        @(negedge clk);
        digits = d; mask = m; lz = l; en = 1'b1;
    endtask

    task automatic wait_anode_a(input logic [3:0] tgt, input string nm);
        int n = 0;
        while (anode_a !== tgt && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (anode_a !== tgt) begin
            checks++;
            errors++;
            $display("FAIL %s: anode timeout got %h expected %h", nm, anode_a, tgt);
        end
    endtask

    task automatic wait_fd(input bit use_b, input string nm, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(use_b ? fd_b : fd_a) && n < 100);
        if (!(use_b ? fd_b : fd_a)) begin
            checks++;
            errors++;
            $display("FAIL %s: frame_done timeout got 0 expected 1", nm);
        end
    endtask

    typedef struct {
        logic [15:0] dig;
        logic [3:0]  msk;
        logic        l;
        logic [27:0] seg;   // {digit3, digit2, digit1, digit0}
    } vec_t;

    vec_t vecs [10];

    initial begin
        int n, dark_cnt, lit2, fd_cnt;
        logic [6:0] xs;
        logic [3:0] xa;

        vecs[0] = '{16'h12AF, 4'h0, 1'b0, {7'h79, 7'h24, 7'h08, 7'h0E}};
        vecs[1] = '{16'h0050, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h12, 7'h40}};
        vecs[2] = '{16'h0000, 4'h0, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h40}};
        vecs[3] = '{16'h0000, 4'h0, 1'b0, {7'h40, 7'h40, 7'h40, 7'h40}};
        vecs[4] = '{16'h3456, 4'hA, 1'b0, {7'h7F, 7'h19, 7'h7F, 7'h02}};
        vecs[5] = '{16'h0809, 4'h0, 1'b1, {7'h7F, 7'h00, 7'h40, 7'h10}};
        vecs[6] = '{16'hBCDE, 4'h0, 1'b1, {7'h03, 7'h46, 7'h21, 7'h06}};
        vecs[7] = '{16'h7000, 4'h0, 1'b1, {7'h78, 7'h40, 7'h40, 7'h40}};
        vecs[8] = '{16'h0003, 4'h1, 1'b1, {7'h7F, 7'h7F, 7'h7F, 7'h7F}};
        vecs[9] = '{16'h6789, 4'h0, 1'b0, {7'h02, 7'h78, 7'h00, 7'h10}};

        // Reset held with Enable high keeps everything dark.
        repeat (3) begin
            @(negedge clk);
            chk("rst_seg", 32'(seg_a), 32'h7F);
            chk("rst_anode", 32'(anode_a), 32'hF);
            chk("rst_fd", 32'(fd_a), 32'h0);
        end
        rst = 1'b0;
        repeat (2) begin
            @(negedge clk);
            chk("first_blank_anode", 32'(anode_a), 32'hF);
        end
        @(negedge clk);
        chk("first_drive_anode", 32'(anode_a), 32'hE);
        chk("first_drive_seg", 32'(seg_a), 32'h0E);

        // Table: one full frame per vector, checked in every DRIVE cycle.
        for (int v = 0; v < 10; v++) begin
            restart(vecs[v].dig, vecs[v].msk, vecs[v].l);
            for (int k = 0; k < PER_A; k++) begin
                @(negedge clk);
                if (k % (BLANK_A + DWELL) >= BLANK_A) begin
                    xs = vecs[v].seg[(k / (BLANK_A + DWELL)) * 7 +: 7];
                    xa = (xs == 7'h7F) ? 4'hF : ~(4'b0001 << (k / (BLANK_A + DWELL)));
                    chk($sformatf("vec%0d_k%0d_seg", v, k), 32'(seg_a), 32'(xs));
                    chk($sformatf("vec%0d_k%0d_anode", v, k), 32'(anode_a), 32'(xa));
                end
                chk($sformatf("vec%0d_k%0d_fd", v, k), 32'(fd_a), 32'(k == PER_A - 1));
            end
        end

        // Frame_Done period.
        restart(16'h12AF, 4'h0, 1'b0);
        wait_fd(0, "fd_first", n);
        repeat (2) begin
            wait_fd(0, "fd_next", n);
            chk("fd_period_a", 32'(n), 32'(PER_A));
        end

        // Mid-frame input change stays invisible until the next frame.
        restart(16'h1111, 4'h0, 1'b0);
        wait_anode_a(4'hD, "t4_d1");
        digits = 16'h2222;
        wait_anode_a(4'hB, "t4_d2");
        chk("notear_d2", 32'(seg_a), 32'h79);
        wait_anode_a(4'h7, "t4_d3");
        chk("notear_d3", 32'(seg_a), 32'h79);
        wait_anode_a(4'hE, "t4_next_d0");
        chk("newframe_d0", 32'(seg_a), 32'h24);
        wait_anode_a(4'hD, "t4_next_d1");
        chk("newframe_d1", 32'(seg_a), 32'h24);

        // Enable dropped during digit 2 DRIVE, then re-raised.
        restart(16'h12AF, 4'h0, 1'b0);
        wait_anode_a(4'hB, "t5_d2");
        en = 1'b0;
        @(negedge clk);
        chk("drop_anode", 32'(anode_a), 32'hF);
        chk("drop_seg", 32'(seg_a), 32'h7F);
        chk("drop_fd", 32'(fd_a), 32'h0);
        chk("drop_sel", 32'(sel_a), 32'h0);
        en = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reen_blank_anode", 32'(anode_a), 32'hF);
        end
        @(negedge clk);
        chk("reen_anode", 32'(anode_a), 32'hE);
        chk("reen_seg", 32'(seg_a), 32'h0E);
        chk("reen_sel", 32'(sel_a), 32'h0);

        // No BLANK slot, digit 2 masked: 16-cycle frame, only digit 2's slot dark.
        restart(16'h12AF, 4'b0100, 1'b0);
        wait_fd(1, "nb_fd_first", n);
        dark_cnt = 0; lit2 = 0; fd_cnt = 0;
        for (int k = 1; k <= PER_B; k++) begin
            @(negedge clk);
            if (anode_b == 4'hF) dark_cnt++;
            if (!anode_b[2]) lit2++;
            if (fd_b) fd_cnt++;
        end
        chk("nb_fd_at_16", 32'(fd_b), 32'h1);
        chk("nb_fd_count", 32'(fd_cnt), 32'h1);
        chk("nb_dark_cycles", 32'(dark_cnt), 32'd4);
        chk("nb_digit2_lit", 32'(lit2), 32'd0);

        // Randomized stimulus; the model monitor checks every cycle.
        for (int it = 0; it < 250; it++) begin
            @(negedge clk);
            digits = 16'($urandom) >> (4 * $urandom_range(0, 4));
            lz     = 1'($urandom_range(0, 1));
            mask   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            en     = ($urandom_range(0, 9) != 0);
            rst    = ($urandom_range(0, 39) == 0);
            repeat ($urandom_range(0, 29)) @(negedge clk);
            rst = 1'b0;
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
